avalon_sram_ctrl: RTL and testbench
===================================

Name: avalon_sram_ctrl

Overview:
- Parametrised Avalon-MM pipelined slave fronting an on-chip SRAM array. It is the successor to the fixed 8-bit SRAM slave.
- Configurable data width, depth and read latency. Active-low byte enables.
- Optional zero-initialisation after reset, with waitrequest held during the clear.
- Sticky error interrupt for protocol and range violations.
- Sits on the peripheral interconnect as general scratch/frame-line storage for the image pipeline.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8, minimum 8.
- DEPTH, 1024, number of DATA_W-bit words; power of 2.
- ADDR_W, 32, byte-address width.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; range 1..8.
- CLEAR_ON_RESET, 1, if 1, zero the whole array after reset release.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- address  in  ADDR_W  byte address; word index = address >> log2(DATA_W/8)
- writedata  in  DATA_W  write data
- byteenable_n  in  DATA_W/8  active-low byte-lane enables
- readdata  out  DATA_W  read data; zero whenever readdatavalid=0
- readdatavalid  out  1  readdata valid strobe
- waitrequest  out  1  slave not accepting commands
- irq_clear  in  1  clears sticky irq
- irq  out  1  sticky error interrupt

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous assert, active-low, synchronous release.
- Reset values:
  - waitrequest=1, readdatavalid=0, readdata=0, irq=0.
  - Read pipeline valid bits cleared; clear counter=0.
  - FSM enters INIT if CLEAR_ON_RESET=1, else READY.
  - Array contents are not reset.
- FSM INIT:
  - Writes zero to mem[clr_idx] each cycle, clr_idx increments.
  - At clr_idx==DEPTH-1, transitions to READY on the next edge.
  - waitrequest=1 throughout, so INIT lasts exactly DEPTH cycles.
  - Bus commands are ignored in INIT; no error is flagged.
- FSM READY:
  - waitrequest=0 combinationally and stays 0; no other state is reachable except via reset.
- Command acceptance: a command is accepted on a rising edge with waitrequest=0 and chipselect=1, plus exactly one of read_n=0 or write_n=0.
- Write:
  - Each byte lane i with byteenable_n[i]=0 is updated at the accept edge; other lanes are preserved.
  - All lanes disabled is a legal no-op.
- Read:
  - The array is sampled at the accept edge.
  - readdatavalid=1 exactly READ_LATENCY cycles after the accept edge (LAT=1 means the next cycle).
  - Read ignores byteenable_n and always returns the full word.
- Throughput: one read or write per cycle; reads fully pipelined with no backpressure.
- Ordering:
  - A read accepted in the cycle after a write to the same word returns the new data.
  - A write and a read to the same word are never accepted in the same edge.
- Errors (each sets irq sticky at the edge):
  - Word index >= DEPTH: the write is dropped; a read still produces readdatavalid with readdata=0, preserving the response count.
  - read_n=0 and write_n=0 together with chipselect=1: no-op, no response.
  - irq_clear=1 clears irq. If a new error occurs in the same edge, set wins and irq stays 1.
- Reset mid-operation: in-flight reads are discarded with no readdatavalid; the FSM restarts INIT or READY per CLEAR_ON_RESET.
- Width rules:
  - Word index uses the low log2(DEPTH) bits after the byte shift.
  - The range check compares the full shifted address against DEPTH.

Decomposition:
- Package avalon_sram_pkg:
  - state enum {INIT, READY}.
  - Function clog2-based byte-shift constant.
  - MAX_READ_LATENCY=8.
- Sub-module sram_read_pipe:
  - Parametrised READ_LATENCY shift register of {valid, data}, async-cleared valid bits.
  - Emits readdatavalid/readdata.

Test Plan:
- INIT clear: DEPTH=16, CLEAR_ON_RESET=1, release reset -> waitrequest=1 for exactly 16 cycles, then 0; read of word 5 returns 0x00000000.
- Byte-lane write: write 0xAABBCCDD to byte address 0x10, then 0x11223344 with byteenable_n=4'b1010 -> read of 0x10 returns 0xAA22CC44.
- Pipelined reads: READ_LATENCY=3, back-to-back reads of words 0,1,2,3 holding 0x0..0x3 -> readdatavalid high 4 consecutive cycles, starting 3 cycles after the first accept, data 0,1,2,3 in order.
- Read-after-write: write 0xDEADBEEF to word 7, read word 7 next cycle -> returns 0xDEADBEEF.
- Errors: read at word 20 with DEPTH=16 -> readdatavalid with readdata=0 and irq=1. Then irq_clear together with a simultaneous read_n=0/write_n=0 strobe -> irq stays 1. Then irq_clear alone -> irq=0.
- Mid-read reset: issue 2 reads with LAT=2, assert rst_n low one cycle after the first accept -> no readdatavalid observed; waitrequest=1 and INIT restarts.

Source files
------------

// File: rtl/avalon_sram_pkg.sv
// Shared types and constants for the Avalon-MM SRAM slave and its read pipeline.
package avalon_sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int MAX_READ_LATENCY = 8;

  // Number of low address bits that select a byte within one data word.
  function automatic int byte_shift(input int data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Fixed-latency read return pipeline: carries {valid, data} from the accept
// edge to the bus, one stage per cycle of latency.
module sram_read_pipe
  import avalon_sram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              readdatavalid,
  output logic [DATA_W-1:0] readdata
);

  // Latency is clamped into the supported range so a bad parameter cannot
  // produce a zero-width or oversized pipe.
  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

  logic [LAT-1:0]    valid_q;
  logic [DATA_W-1:0] data_q [LAT];

  // Valid bits are reset so that a reset drops every in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Data stages need no reset; the output is masked by the valid bit.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < LAT; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign readdatavalid = valid_q[LAT-1];
  assign readdata      = valid_q[LAT-1] ? data_q[LAT-1] : '0;

endmodule

// File: rtl/avalon_sram_ctrl.sv
// Avalon-MM pipelined slave in front of an on-chip SRAM array with byte-lane
// writes, fixed-latency pipelined reads, optional post-reset clear and a
// sticky error interrupt. DEPTH must be a power of two and at least 2.
module avalon_sram_ctrl
  import avalon_sram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chipselect,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W/8-1:0] byteenable_n,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  input  logic                irq_clear,
  output logic                irq
);

  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = byte_shift(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DEPTH - 1);
  localparam sram_state_e       RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : READY;

  sram_state_e       state_q;
  sram_state_e       state_d;
  logic [IDX_W-1:0]  clr_idx_q;
  logic [IDX_W-1:0]  clr_idx_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic              both_strobes;
  logic              err;
  logic [DATA_W-1:0] rd_data;

  // The range check uses the whole shifted address so that aliases above
  // DEPTH are caught rather than silently wrapping onto low words.
  assign word_addr = address >> SHIFT;
  assign word_idx  = word_addr[IDX_W-1:0];
  assign in_range  = (word_addr < DEPTH_LIMIT);

  assign waitrequest  = (state_q != READY);
  assign rd_acc       = !waitrequest && chipselect && !read_n &&  write_n;
  assign wr_acc       = !waitrequest && chipselect &&  read_n && !write_n;
  assign both_strobes = !waitrequest && chipselect && !read_n && !write_n;
  assign err          = both_strobes || ((rd_acc || wr_acc) && !in_range);

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // INIT walks every word once, then READY is held until the next reset.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      INIT: begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = READY;
          clr_idx_d = '0;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Array update: zero fill during INIT, byte-lane writes when READY.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < BYTES; i++) begin
        if (!byteenable_n[i]) begin
          mem[word_idx][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
    end
  end

  // Out-of-range reads still return a word so the response count matches.
  assign rd_data = in_range ? mem[word_idx] : '0;

  // Sticky interrupt; a new error outranks a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (err) begin
      irq <= 1'b1;
    end else if (irq_clear) begin
      irq <= 1'b0;
    end
  end

  sram_read_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (rd_acc),
    .in_data       (rd_data),
    .readdatavalid (readdatavalid),
    .readdata      (readdata)
  );

endmodule

// File: tb/tb_avalon_sram_ctrl.sv
// Directed bench for avalon_sram_ctrl: two instances (latency 3 and 2) share
// one bus; expectations are hand-computed constants.
module tb_avalon_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable_n;
  logic        irq_clear;

  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        irq;

  logic [31:0] readdata2;
  logic        readdatavalid2;
  logic        waitrequest2;
  logic        irq2;

  int checks = 0;
  int errors = 0;

  avalon_sram_ctrl #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(32), .READ_LATENCY(3), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .address(address), .writedata(writedata),
    .byteenable_n(byteenable_n), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .irq_clear(irq_clear), .irq(irq)
  );

  avalon_sram_ctrl #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(32), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .address(address), .writedata(writedata),
    .byteenable_n(byteenable_n), .readdata(readdata2),
    .readdatavalid(readdatavalid2), .waitrequest(waitrequest2),
    .irq_clear(irq_clear), .irq(irq2)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic cs, input logic rn, input logic wn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be_n, input logic ic);
    chipselect   = cs;
    read_n       = rn;
    write_n      = wn;
    address      = addr;
    writedata    = wd;
    byteenable_n = be_n;
    irq_clear    = ic;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
  endtask

  // Drive one command at a falling edge, let the next rising edge take it,
  // and return at the following falling edge with the bus idle.
  task automatic bus_cycle(input logic rn, input logic wn, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be_n);
    applyStimulus(1'b1, rn, wn, addr, wd, be_n, 1'b0);
    @(negedge clk);
    idle();
  endtask

  // Count rising edges with waitrequest high after a reset release.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (waitrequest && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, n, 16);
    @(negedge clk);
    checkOutput({tag, "_wr0"}, {31'b0, waitrequest2}, 32'h0);
  endtask

  // Single read on the latency-3 instance: check arrival cycle and data.
  task automatic read_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] expected);
    int k;
    bus_cycle(1'b0, 1'b1, addr, 32'h0, 4'hF);
    k = 1;
    while (!readdatavalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_lat"}, k, 3);
    checkOutput({tag, "_data"}, readdata, expected);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    checkOutput("rst_waitrequest", {31'b0, waitrequest}, 32'h1);
    checkOutput("rst_rdvalid", {31'b0, readdatavalid}, 32'h0);
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_cycles");
    checkOutput("ready_wr", {31'b0, waitrequest}, 32'h0);
    read_check("init_word5", 32'h14, 32'h0);

    // Byte-lane write: lanes 0 and 2 enabled on the second write.
    bus_cycle(1'b1, 1'b0, 32'h10, 32'hAABBCCDD, 4'b0000);
    bus_cycle(1'b1, 1'b0, 32'h10, 32'h11223344, 4'b1010);
    read_check("byte_lane", 32'h10, 32'hAA22CC44);

    // Back-to-back reads of words 0..3 holding 0..3.
    for (int w = 0; w < 4; w++) begin
      bus_cycle(1'b1, 1'b0, 32'(w * 4), 32'(w), 4'b0000);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      if (t < 4) applyStimulus(1'b1, 1'b0, 1'b1, 32'(t * 4), 32'h0, 4'hF, 1'b0);
      else idle();
      checkOutput($sformatf("pipe3_v%0d", t), {31'b0, readdatavalid},
                  (t >= 3 && t <= 6) ? 32'h1 : 32'h0);
      checkOutput($sformatf("pipe3_d%0d", t), readdata,
                  (t >= 3 && t <= 6) ? 32'(t - 3) : 32'h0);
      checkOutput($sformatf("pipe2_v%0d", t), {31'b0, readdatavalid2},
                  (t >= 2 && t <= 5) ? 32'h1 : 32'h0);
      checkOutput($sformatf("pipe2_d%0d", t), readdata2,
                  (t >= 2 && t <= 5) ? 32'(t - 2) : 32'h0);
    end

    // Read issued the cycle right after a write to the same word.
    bus_cycle(1'b1, 1'b0, 32'h1C, 32'hDEADBEEF, 4'b0000);
    read_check("raw", 32'h1C, 32'hDEADBEEF);

    // Out-of-range read still answers with zero and raises irq.
    checkOutput("irq_before_err", {31'b0, irq}, 32'h0);
    read_check("oor_read", 32'h50, 32'h0);
    checkOutput("irq_oor_read", {31'b0, irq}, 32'h1);

    // Clear together with a double strobe: the new error wins, no response.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h14, 32'hFFFFFFFF, 4'b0000, 1'b1);
    @(negedge clk);
    idle();
    checkOutput("irq_set_wins", {31'b0, irq}, 32'h1);
    for (int t = 0; t < 4; t++) begin
      checkOutput($sformatf("dbl_noresp%0d", t), {31'b0, readdatavalid}, 32'h0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
    @(negedge clk);
    idle();
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);

    // Out-of-range write aliasing word 5 must be dropped and flag irq.
    bus_cycle(1'b1, 1'b0, 32'h54, 32'h12345678, 4'b0000);
    checkOutput("irq_oor_write", {31'b0, irq}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
    @(negedge clk);
    idle();
    read_check("oor_write_drop", 32'h14, 32'h0);

    // Reset half a cycle after the first read is accepted.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1C, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    rst_n = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1;
      checkOutput($sformatf("mid_rst_v3_%0d", t), {31'b0, readdatavalid}, 32'h0);
      checkOutput($sformatf("mid_rst_v2_%0d", t), {31'b0, readdatavalid2}, 32'h0);
      checkOutput($sformatf("mid_rst_wr_%0d", t), {31'b0, waitrequest}, 32'h1);
      @(negedge clk);
    end
    idle();
    rst_n = 1'b1;
    wait_init("reinit_cycles");
    read_check("reinit_word7", 32'h1C, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
